// File: rtl/mm_order_scheduler.sv
// Order scheduler between market_maker strobes and the exchange order port: captures
// buy/sell requests, enforces net-position and token-bucket limits, issues one order at a time.
module mm_order_scheduler #(
  parameter int PRICE_W    = 16,
  parameter int POS_W      = 8,
  parameter int MAX_POS    = 16,
  parameter int BURST      = 4,
  parameter int REFILL_CYC = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       buy_order,
  input  logic                       sell_order,
  input  logic [PRICE_W-1:0]         buy_price,
  input  logic [PRICE_W-1:0]         sell_price,
  input  logic                       halt,
  output logic                       ord_valid,
  input  logic                       ord_ready,
  output logic                       ord_side,
  output logic [PRICE_W-1:0]         ord_price,
  output logic [POS_W-1:0]           position,
  output logic [$clog2(BURST+1)-1:0] tokens,
  output logic                       busy
);

  localparam int TOK_W = $clog2(BURST + 1);
  localparam int CNT_W = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;

  localparam logic signed [POS_W-1:0] POS_HI   = POS_W'(MAX_POS);
  localparam logic signed [POS_W-1:0] POS_LO   = POS_W'(-MAX_POS);
  localparam logic [TOK_W-1:0]        TOK_FULL = TOK_W'(BURST);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(REFILL_CYC - 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                    state_q,      state_d;
  logic                      ord_valid_q,  ord_valid_d;
  logic                      ord_side_q,   ord_side_d;
  logic [PRICE_W-1:0]        ord_price_q,  ord_price_d;
  logic signed [POS_W-1:0]   position_q,   position_d;
  logic [TOK_W-1:0]          tokens_q,     tokens_d;
  logic                      busy_q,       busy_d;
  logic                      buy_pend_q,   buy_pend_d;
  logic                      sell_pend_q,  sell_pend_d;
  logic [PRICE_W-1:0]        buy_price_q,  buy_price_d;
  logic [PRICE_W-1:0]        sell_price_q, sell_price_d;
  logic                      last_side_q,  last_side_d;
  logic [CNT_W-1:0]          refill_cnt_q, refill_cnt_d;

  logic buy_elig;
  logic sell_elig;
  logic grant;
  logic grant_sell;
  logic refill;

  always_comb begin
    state_d      = state_q;
    ord_valid_d  = ord_valid_q;
    ord_side_d   = ord_side_q;
    ord_price_d  = ord_price_q;
    position_d   = position_q;
    tokens_d     = tokens_q;
    busy_d       = busy_q;
    buy_pend_d   = buy_pend_q;
    sell_pend_d  = sell_pend_q;
    buy_price_d  = buy_price_q;
    sell_price_d = sell_price_q;
    last_side_d  = last_side_q;

    buy_elig   = buy_pend_q && (position_q < POS_HI);
    sell_elig  = sell_pend_q && (position_q > POS_LO);
    grant_sell = sell_elig && (!buy_elig || !last_side_q);
    grant      = 1'b0;

    refill       = (refill_cnt_q == CNT_LAST);
    refill_cnt_d = refill ? '0 : refill_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (!halt && (tokens_q != '0) && (buy_elig || sell_elig)) begin
          grant       = 1'b1;
          state_d     = ISSUE;
          ord_valid_d = 1'b1;
          busy_d      = 1'b1;
          ord_side_d  = grant_sell;
          ord_price_d = grant_sell ? sell_price_q : buy_price_q;
          last_side_d = grant_sell;
          if (grant_sell) sell_pend_d = 1'b0;
          else            buy_pend_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (ord_ready) begin
          position_d  = ord_side_q ? position_q - POS_W'(1) : position_q + POS_W'(1);
          ord_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture after the grant clear so a same-cycle strobe re-arms the side with its new price.
    if (buy_order) begin
      buy_pend_d  = 1'b1;
      buy_price_d = buy_price;
    end
    if (sell_order) begin
      sell_pend_d  = 1'b1;
      sell_price_d = sell_price;
    end

    if (grant) tokens_d = tokens_q - TOK_W'(1);
    if (refill && (tokens_d != TOK_FULL)) tokens_d = tokens_d + TOK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ord_valid_q  <= 1'b0;
      ord_side_q   <= 1'b0;
      ord_price_q  <= '0;
      position_q   <= '0;
      tokens_q     <= TOK_FULL;
      busy_q       <= 1'b0;
      buy_pend_q   <= 1'b0;
      sell_pend_q  <= 1'b0;
      buy_price_q  <= '0;
      sell_price_q <= '0;
      last_side_q  <= 1'b1;
      refill_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ord_valid_q  <= ord_valid_d;
      ord_side_q   <= ord_side_d;
      ord_price_q  <= ord_price_d;
      position_q   <= position_d;
      tokens_q     <= tokens_d;
      busy_q       <= busy_d;
      buy_pend_q   <= buy_pend_d;
      sell_pend_q  <= sell_pend_d;
      buy_price_q  <= buy_price_d;
      sell_price_q <= sell_price_d;
      last_side_q  <= last_side_d;
      refill_cnt_q <= refill_cnt_d;
    end
  end

  assign ord_valid = ord_valid_q;
  assign ord_side  = ord_side_q;
  assign ord_price = ord_price_q;
  assign position  = position_q;
  assign tokens    = tokens_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mm_order_scheduler.sv
// Bench for mm_order_scheduler: directed scenarios plus randomized traffic against an
// integer-arithmetic reference model of the scheduling rules.
module tb_mm_order_scheduler;

  localparam int PRICE_W    = 16;
  localparam int POS_W      = 8;
  localparam int MAX_POS    = 16;
  localparam int BURST      = 4;
  localparam int REFILL_CYC = 10;
  localparam int TOK_W      = $clog2(BURST + 1);
  localparam int VW         = 3 + PRICE_W + POS_W + TOK_W;

  logic               clk = 1'b0;
  logic               reset, buy_order, sell_order, halt, ord_ready;
  logic [PRICE_W-1:0] buy_price, sell_price, ord_price;
  logic               ord_valid, ord_side, busy;
  logic [POS_W-1:0]   position;
  logic [TOK_W-1:0]   tokens;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  logic prev_valid;

  always #5 clk = ~clk;

  mm_order_scheduler #(
    .PRICE_W(PRICE_W), .POS_W(POS_W), .MAX_POS(MAX_POS),
    .BURST(BURST), .REFILL_CYC(REFILL_CYC)
  ) dut (
    .clk(clk), .reset(reset), .buy_order(buy_order), .sell_order(sell_order),
    .buy_price(buy_price), .sell_price(sell_price), .halt(halt),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_side(ord_side),
    .ord_price(ord_price), .position(position), .tokens(tokens), .busy(busy)
  );

  // Reference model: plain integers describing pending requests, bucket and position.
  int m_pos, m_tok, m_cnt, m_bpr, m_spr, m_price;
  bit m_bp, m_sp, m_last, m_iss, m_side;

  task automatic model_edge();
    bit be, se, gs;
    if (reset) begin
      m_iss = 0; m_side = 0; m_price = 0; m_pos = 0; m_tok = BURST; m_cnt = 0;
      m_bp = 0; m_sp = 0; m_last = 1; m_bpr = 0; m_spr = 0;
    end else begin
      be = m_bp && (m_pos + 1 <= MAX_POS);
      se = m_sp && (m_pos - 1 >= -MAX_POS);
      if (m_iss) begin
        if (ord_ready) begin
          m_pos += m_side ? -1 : 1;
          m_iss = 0;
        end
      end else if (!halt && m_tok > 0 && (be || se)) begin
        gs = (be && se) ? !m_last : se;
        m_iss = 1; m_side = gs; m_last = gs; m_tok--;
        if (gs) begin m_price = m_spr; m_sp = 0; end
        else    begin m_price = m_bpr; m_bp = 0; end
      end
      if (buy_order)  begin m_bp = 1; m_bpr = int'(buy_price);  end
      if (sell_order) begin m_sp = 1; m_spr = int'(sell_price); end
      if (m_cnt == REFILL_CYC - 1) begin
        m_cnt = 0;
        if (m_tok < BURST) m_tok++;
      end else m_cnt++;
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {ord_valid, busy, ord_side, ord_price, position, tokens};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_iss, m_iss, m_side, PRICE_W'(m_price), POS_W'(m_pos), TOK_W'(m_tok)};
  endfunction

  task automatic step();
    model_edge();
    prev_valid = ord_valid;
    @(posedge clk);
    #1;
    if (ord_valid === 1'b1 && prev_valid !== 1'b1) rises++;
  endtask

  task automatic clear_inputs();
    buy_order = 0; sell_order = 0; halt = 0; ord_ready = 0;
    buy_price = '0; sell_price = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    rises = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    buy_order = 1; sell_order = 1; buy_price = 16'hBEEF;
    step();
    step();
    checks++;
    if ({ord_valid, busy, ord_side, ord_price} !== {1'b0, 1'b0, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b %h want=000 0000", ord_valid, busy, ord_side, ord_price);
    end
    checks++;
    if (position !== '0 || tokens !== TOK_W'(BURST)) begin
      failures++;
      $display("FAIL reset_pos_tok got pos=%0d tok=%0d want pos=0 tok=%0d", $signed(position), tokens, BURST);
    end
    reset = 0;
    clear_inputs();
    step();
    checks++;
    if (ord_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_clears_pend got valid=%b want 0", ord_valid);
    end
  endtask

  task automatic test_single_buy();
    do_reset();
    ord_ready = 1; buy_order = 1; buy_price = 16'd100;
    step();
    buy_order = 0;
    checks++;
    if (ord_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_latency got valid=%b after strobe edge want 0", ord_valid);
    end
    step();
    checks++;
    if ({ord_valid, busy, ord_side, ord_price, tokens} !== {1'b1, 1'b1, 1'b0, 16'd100, TOK_W'(BURST - 1)}) begin
      failures++;
      $display("FAIL single_grant got v=%b b=%b s=%b p=%0d t=%0d want v=1 b=1 s=0 p=100 t=%0d",
               ord_valid, busy, ord_side, ord_price, tokens, BURST - 1);
    end
    step();
    checks++;
    if (ord_valid !== 1'b0 || position !== POS_W'(1)) begin
      failures++;
      $display("FAIL single_handshake got v=%b pos=%0d want v=0 pos=1", ord_valid, $signed(position));
    end
  endtask

  task automatic test_both_sides();
    do_reset();
    ord_ready = 1;
    buy_order = 1; buy_price = 16'd200; sell_order = 1; sell_price = 16'd300;
    step();
    buy_order = 0; sell_order = 0;
    step();
    checks++;
    if ({ord_valid, ord_side, ord_price} !== {1'b1, 1'b0, 16'd200}) begin
      failures++;
      $display("FAIL both_first got v=%b s=%b p=%0d want v=1 s=0 p=200", ord_valid, ord_side, ord_price);
    end
    step();
    checks++;
    if (ord_valid !== 1'b0 || position !== POS_W'(1)) begin
      failures++;
      $display("FAIL both_gap got v=%b pos=%0d want v=0 pos=1", ord_valid, $signed(position));
    end
    step();
    checks++;
    if ({ord_valid, ord_side, ord_price} !== {1'b1, 1'b1, 16'd300}) begin
      failures++;
      $display("FAIL both_second got v=%b s=%b p=%0d want v=1 s=1 p=300", ord_valid, ord_side, ord_price);
    end
    step();
    checks++;
    if (position !== '0) begin
      failures++;
      $display("FAIL both_position got pos=%0d want 0", $signed(position));
    end
  endtask

  task automatic test_token_limit();
    do_reset();
    ord_ready = 1;
    for (int e = 1; e <= 12; e++) begin
      if (e % 2 == 1) begin
        if (((e - 1) / 2) % 2 == 0) begin buy_order = 1;  buy_price  = PRICE_W'(e); end
        else                        begin sell_order = 1; sell_price = PRICE_W'(e); end
      end
      step();
      buy_order = 0; sell_order = 0;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL tokens_model edge%0d got=%h want=%h", e, dut_vec(), mdl_vec());
      end
      if (e == 8) begin
        checks++;
        if (tokens !== '0) begin
          failures++;
          $display("FAIL tokens_empty got tok=%0d want 0", tokens);
        end
      end
      if (e == 10) begin
        checks++;
        if (rises != 4 || ord_valid !== 1'b0 || tokens !== TOK_W'(1)) begin
          failures++;
          $display("FAIL tokens_block got orders=%0d v=%b tok=%0d want orders=4 v=0 tok=1", rises, ord_valid, tokens);
        end
      end
      if (e == 11) begin
        checks++;
        if (rises != 5 || ord_side !== 1'b0) begin
          failures++;
          $display("FAIL tokens_refill_grant got orders=%0d side=%b want orders=5 side=0", rises, ord_side);
        end
      end
    end
  endtask

  task automatic test_position_limit();
    bit rs[2];
    int rp[2];
    int old;
    do_reset();
    ord_ready = 1;
    for (int i = 0; i <= 16; i++) begin
      buy_order = 1; buy_price = PRICE_W'(1000 + i);
      step();
      buy_order = 0;
      repeat (14) step();
    end
    checks++;
    if (position !== POS_W'(MAX_POS) || ord_valid !== 1'b0 || rises != 16) begin
      failures++;
      $display("FAIL poslimit_saturate got pos=%0d v=%b orders=%0d want pos=%0d v=0 orders=16",
               $signed(position), ord_valid, rises, MAX_POS);
    end
    rises = 0;
    sell_order = 1; sell_price = 16'd2000;
    for (int k = 0; k < 20; k++) begin
      old = rises;
      step();
      sell_order = 0;
      if (rises != old && rises <= 2) begin
        rs[rises-1] = ord_side;
        rp[rises-1] = int'(ord_price);
      end
    end
    checks++;
    if (rises != 2 || rs[0] != 1'b1 || rp[0] != 2000 || rs[1] != 1'b0 || rp[1] != 1016) begin
      failures++;
      $display("FAIL poslimit_release got orders=%0d s0=%b p0=%0d s1=%b p1=%0d want orders=2 s0=1 p0=2000 s1=0 p1=1016",
               rises, rs[0], rp[0], rs[1], rp[1]);
    end
    checks++;
    if (position !== POS_W'(MAX_POS)) begin
      failures++;
      $display("FAIL poslimit_final got pos=%0d want %0d", $signed(position), MAX_POS);
    end
  endtask

  task automatic test_stall_halt();
    do_reset();
    buy_order = 1; buy_price = 16'h1234;
    step();
    buy_order = 0;
    step();
    for (int k = 0; k < 5; k++) begin
      halt = (k == 1 || k == 2);
      if (k == 0) begin sell_order = 1; sell_price = 16'h0055; end
      step();
      sell_order = 0;
      checks++;
      if ({ord_valid, busy, ord_side, ord_price} !== {1'b1, 1'b1, 1'b0, 16'h1234}) begin
        failures++;
        $display("FAIL stall_hold cyc%0d got v=%b b=%b s=%b p=%h want v=1 b=1 s=0 p=1234",
                 k, ord_valid, busy, ord_side, ord_price);
      end
    end
    halt = 1; ord_ready = 1;
    step();
    checks++;
    if (ord_valid !== 1'b0 || position !== POS_W'(1)) begin
      failures++;
      $display("FAIL halt_handshake got v=%b pos=%0d want v=0 pos=1", ord_valid, $signed(position));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (ord_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt_blocks cyc%0d got v=%b want 0", k, ord_valid);
      end
    end
    halt = 0;
    step();
    checks++;
    if ({ord_valid, ord_side, ord_price} !== {1'b1, 1'b1, 16'h0055}) begin
      failures++;
      $display("FAIL halt_release got v=%b s=%b p=%h want v=1 s=1 p=0055", ord_valid, ord_side, ord_price);
    end
    step();
    checks++;
    if (position !== '0) begin
      failures++;
      $display("FAIL halt_final_pos got pos=%0d want 0", $signed(position));
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    buy_order = 1; buy_price = 16'd77;
    step();
    buy_order = 0;
    step();
    step();
    checks++;
    if (ord_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_setup got v=%b want 1", ord_valid);
    end
    reset = 1; ord_ready = 1;
    step();
    reset = 0; ord_ready = 0;
    checks++;
    if ({ord_valid, busy} !== 2'b00 || position !== '0 || tokens !== TOK_W'(BURST)) begin
      failures++;
      $display("FAIL midreset got v=%b b=%b pos=%0d tok=%0d want v=0 b=0 pos=0 tok=%0d",
               ord_valid, busy, $signed(position), tokens, BURST);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c < 400) begin
        buy_order  = ($urandom_range(0, 1) == 0);
        sell_order = ($urandom_range(0, 7) == 0);
      end else begin
        buy_order  = ($urandom_range(0, 7) == 0);
        sell_order = ($urandom_range(0, 1) == 0);
      end
      buy_price  = PRICE_W'($urandom);
      sell_price = PRICE_W'($urandom);
      ord_ready  = ($urandom_range(0, 3) != 0);
      halt       = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL random cyc%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_single_buy();
    test_both_sides();
    test_token_limit();
    test_position_limit();
    test_stall_halt();
    test_reset_mid_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
